// File: rtl/register_bank.sv
// Architectural state of the 4-bit CPU: A, B, OUT, PC and carry.
// Optional input synchronizer enabled by defining IN_SYNC_EN.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-high; beats en and load_sel
//   en         advance enable; 0 freezes every register
//   load_sel   write strobes {PC, OUT, B, A}
//   data_in    ALU result written back to the selected registers
//   carry_in   ALU carry of the current instruction
//   in_port    external input switches
//   reg_a      register A, to the ALU-input multiplexer
//   reg_b      register B, to the ALU-input multiplexer
//   in_port_q  input port value, to the ALU-input multiplexer
//   out_port   output port register
//   pc         program counter / ROM address
//   carry_flag carry of the previous instruction (JNC condition)
//   pc_wrap    one-cycle pulse after PC increments from all-ones to 0
//
// Configuration:
//   IN_SYNC_EN defined   : in_port goes through a 2-flop synchronizer,
//                          reset to 0, clocked by clk and not gated by en.
//   IN_SYNC_EN undefined : in_port_q is in_port, combinationally.

module register_bank #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       load_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] in_port_q,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] pc,
  output logic             carry_flag,
  output logic             pc_wrap
);

  localparam int SEL_A   = 0;
  localparam int SEL_B   = 1;
  localparam int SEL_OUT = 2;
  localparam int SEL_PC  = 3;

  logic [WIDTH-1:0] a_q,   a_d;
  logic [WIDTH-1:0] b_q,   b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] pc_q,  pc_d;
  logic             c_q,   c_d;
  logic             w_q,   w_d;

  logic [WIDTH-1:0] pc_inc;
  logic             pc_at_max;

  assign pc_inc    = pc_q + 1'b1;
  assign pc_at_max = (pc_q == '1);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    pc_d  = pc_q;
    c_d   = c_q;
    w_d   = 1'b0;
    if (en) begin
      if (load_sel[SEL_A])   a_d   = data_in;
      if (load_sel[SEL_B])   b_d   = data_in;
      if (load_sel[SEL_OUT]) out_d = data_in;
      c_d = carry_in;
      if (load_sel[SEL_PC]) begin
        pc_d = data_in;
      end else begin
        pc_d = pc_inc;
        // Only a genuine increment out of all-ones counts as a wrap;
        // a jump that happens to land on 0 does not.
        w_d  = pc_at_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      pc_q  <= PC_RESET;
      c_q   <= 1'b0;
      w_q   <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      pc_q  <= pc_d;
      c_q   <= c_d;
      w_q   <= w_d;
    end
  end

`ifdef IN_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Free-running so the switches keep settling while single-stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  assign in_port_q = sync2_q;
`else
  assign in_port_q = in_port;
`endif

  assign reg_a      = a_q;
  assign reg_b      = b_q;
  assign out_port   = out_q;
  assign pc         = pc_q;
  assign carry_flag = c_q;
  assign pc_wrap    = w_q;

endmodule
